// File: rtl/e203_exu_flush_ctrl_if.sv
// Flush handshake bundle between the branch-resolve/exception sources, the
// flush controller and the IFU.
interface e203_exu_flush_ctrl_if #(
    parameter int PC_SIZE = 32
);
    logic               brchmis_flush_req;
    logic [PC_SIZE-1:0] brchmis_flush_add_op1;
    logic [PC_SIZE-1:0] brchmis_flush_add_op2;
    logic               brchmis_flush_ack;
    logic               excp_flush_req;
    logic [PC_SIZE-1:0] excp_flush_pc;
    logic               excp_flush_ack;
    logic               pipe_flush_req;
    logic [PC_SIZE-1:0] pipe_flush_pc;
    logic               pipe_flush_ack;

    // Environment side: drives requests and the IFU ack.
    modport master (
        output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        output excp_flush_req, excp_flush_pc, pipe_flush_ack,
        input  brchmis_flush_ack, excp_flush_ack, pipe_flush_req, pipe_flush_pc
    );

    // Controller side.
    modport slave (
        input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        input  excp_flush_req, excp_flush_pc, pipe_flush_ack,
        output brchmis_flush_ack, excp_flush_ack, pipe_flush_req, pipe_flush_pc
    );
endinterface

// File: rtl/e203_exu_flush_ctrl.sv
// EXU flush controller: arbitrates exception/branch flushes, latches the target
// PC and holds a registered flush toward the IFU. Counters built with E203_FLUSH_STAT_EN.
module e203_exu_flush_ctrl #(
    parameter int PC_SIZE = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    e203_exu_flush_ctrl_if.slave         flush_if,
    output logic                         flush_busy,
    input  logic                         stat_clr,
    output logic [31:0]                  brch_flush_cnt,
    output logic [31:0]                  excp_flush_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic               can_accept_s;
    logic               excp_ack_s;
    logic               brch_ack_s;
    logic [PC_SIZE-1:0] brch_tgt_s;

    // Arbitration, target selection and next-state logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        can_accept_s = 1'b0;
        case (state_q)
            IDLE:    can_accept_s = 1'b1;
            PEND:    can_accept_s = flush_if.pipe_flush_ack;
            default: can_accept_s = 1'b0;
        endcase
        excp_ack_s = can_accept_s & flush_if.excp_flush_req;
        brch_ack_s = can_accept_s & flush_if.brchmis_flush_req & ~flush_if.excp_flush_req;
        brch_tgt_s = flush_if.brchmis_flush_add_op1 + flush_if.brchmis_flush_add_op2;
        if (excp_ack_s) begin
            pc_d    = {flush_if.excp_flush_pc[PC_SIZE-1:1], 1'b0};
            state_d = PEND;
        end else if (brch_ack_s) begin
            pc_d    = {brch_tgt_s[PC_SIZE-1:1], 1'b0};
            state_d = PEND;
        end else if ((state_q == PEND) && flush_if.pipe_flush_ack) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // State and target PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= {PC_SIZE{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign flush_if.excp_flush_ack    = excp_ack_s;
    assign flush_if.brchmis_flush_ack = brch_ack_s;
    assign flush_if.pipe_flush_req    = (state_q == PEND);
    assign flush_if.pipe_flush_pc     = pc_q;
    assign flush_busy                 = (state_q == PEND);

`ifdef E203_FLUSH_STAT_EN
    logic [31:0] brch_cnt_q, brch_cnt_d;
    logic [31:0] excp_cnt_q, excp_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        brch_cnt_d = brch_cnt_q;
        excp_cnt_d = excp_cnt_q;
        if (stat_clr) begin
            brch_cnt_d = 32'd0;
            excp_cnt_d = 32'd0;
        end else begin
            if (brch_ack_s) begin
                brch_cnt_d = sat_inc(brch_cnt_q);
            end else begin
                brch_cnt_d = brch_cnt_q;
            end
            if (excp_ack_s) begin
                excp_cnt_d = sat_inc(excp_cnt_q);
            end else begin
                excp_cnt_d = excp_cnt_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brch_cnt_q <= 32'd0;
            excp_cnt_q <= 32'd0;
        end else begin
            brch_cnt_q <= brch_cnt_d;
            excp_cnt_q <= excp_cnt_d;
        end
    end

    assign brch_flush_cnt = brch_cnt_q;
    assign excp_flush_cnt = excp_cnt_q;
`else
    logic unused_stat_clr_s;
    assign unused_stat_clr_s = stat_clr;
    assign brch_flush_cnt    = 32'd0;
    assign excp_flush_cnt    = 32'd0;
`endif

endmodule

// File: tb/tb_e203_exu_flush_ctrl.sv
// Directed testbench for e203_exu_flush_ctrl with hand-computed expectations.
module tb_e203_exu_flush_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush_busy;
    logic        stat_clr;
    logic [31:0] brch_flush_cnt;
    logic [31:0] excp_flush_cnt;
    int          checks;
    int          errors;

    e203_exu_flush_ctrl_if #(.PC_SIZE(32)) fif ();

    e203_exu_flush_ctrl #(.PC_SIZE(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_if       (fif),
        .flush_busy     (flush_busy),
        .stat_clr       (stat_clr),
        .brch_flush_cnt (brch_flush_cnt),
        .excp_flush_cnt (excp_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] pc);
        chk({tag, "_req"},  {31'd0, fif.pipe_flush_req}, {31'd0, req});
        chk({tag, "_busy"}, {31'd0, flush_busy},         {31'd0, req});
        chk({tag, "_pc"},   fif.pipe_flush_pc,           pc);
    endtask

    task automatic chk_acks(input string tag, input logic b, input logic e);
        #1;
        chk({tag, "_brch_ack"}, {31'd0, fif.brchmis_flush_ack}, {31'd0, b});
        chk({tag, "_excp_ack"}, {31'd0, fif.excp_flush_ack},    {31'd0, e});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        stat_clr = 1'b0;
        fif.brchmis_flush_req     = 1'b0;
        fif.brchmis_flush_add_op1 = 32'd0;
        fif.brchmis_flush_add_op2 = 32'd0;
        fif.excp_flush_req        = 1'b0;
        fif.excp_flush_pc         = 32'd0;
        fif.pipe_flush_ack        = 1'b0;
        #12;
        chk_out("reset", 1'b0, 32'd0);
        chk_acks("reset", 1'b0, 1'b0);
        chk("reset_bcnt", brch_flush_cnt, 32'd0);
        chk("reset_ecnt", excp_flush_cnt, 32'd0);
        #3 rst_n = 1'b1;

        // Single branch flush with IFU stall of three cycles.
        tick();
        fif.brchmis_flush_req     = 1'b1;
        fif.brchmis_flush_add_op1 = 32'h8000_0100;
        fif.brchmis_flush_add_op2 = 32'h0000_0004;
        chk_acks("br1_n", 1'b1, 1'b0);
        tick();
        fif.brchmis_flush_req = 1'b0;
        chk_out("br1_n1", 1'b1, 32'h8000_0104);
        tick();
        chk_out("br1_n2", 1'b1, 32'h8000_0104);
        tick();
        chk_out("br1_n3", 1'b1, 32'h8000_0104);
        tick();
        fif.pipe_flush_ack = 1'b1;
        chk_out("br1_n4", 1'b1, 32'h8000_0104);
        chk_acks("br1_n4", 1'b0, 1'b0);
        tick();
        fif.pipe_flush_ack = 1'b0;
        chk_out("br1_n5", 1'b0, 32'h8000_0104);

        // Simultaneous sources: exception wins, branch follows back-to-back.
        fif.brchmis_flush_req     = 1'b1;
        fif.brchmis_flush_add_op1 = 32'h0000_0100;
        fif.brchmis_flush_add_op2 = 32'h0000_0020;
        fif.excp_flush_req        = 1'b1;
        fif.excp_flush_pc         = 32'h8000_0000;
        chk_acks("sim_n", 1'b0, 1'b1);
        tick();
        fif.excp_flush_req = 1'b0;
        chk_out("sim_n1", 1'b1, 32'h8000_0000);
        chk_acks("sim_n1_hold", 1'b0, 1'b0);
        tick();
        fif.pipe_flush_ack = 1'b1;
        chk_acks("sim_n2_b2b", 1'b1, 1'b0);
        tick();
        fif.brchmis_flush_req = 1'b0;
        fif.pipe_flush_ack    = 1'b0;
        chk_out("sim_n3", 1'b1, 32'h0000_0120);
        fif.pipe_flush_ack = 1'b1;
        tick();
        fif.pipe_flush_ack = 1'b0;
        chk_out("sim_idle", 1'b0, 32'h0000_0120);

        // Wrap-around with odd sum: carry dropped and bit 0 cleared.
        fif.brchmis_flush_req     = 1'b1;
        fif.brchmis_flush_add_op1 = 32'hFFFF_FFFC;
        fif.brchmis_flush_add_op2 = 32'h0000_0009;
        chk_acks("wrap_n", 1'b1, 1'b0);
        tick();
        fif.brchmis_flush_req = 1'b0;
        chk_out("wrap_n1", 1'b1, 32'h0000_0004);
        fif.pipe_flush_ack = 1'b1;
        tick();
        fif.pipe_flush_ack = 1'b0;

        // Busy blocking: exception waits until the IFU ack cycle.
        fif.brchmis_flush_req     = 1'b1;
        fif.brchmis_flush_add_op1 = 32'h0000_0200;
        fif.brchmis_flush_add_op2 = 32'h0000_0000;
        chk_acks("busy_n", 1'b1, 1'b0);
        tick();
        fif.brchmis_flush_req = 1'b0;
        fif.excp_flush_req    = 1'b1;
        fif.excp_flush_pc     = 32'h0000_3001;
        chk_acks("busy_n1", 1'b0, 1'b0);
        tick();
        chk_acks("busy_n2", 1'b0, 1'b0);
        chk_out("busy_n2", 1'b1, 32'h0000_0200);
        tick();
        fif.pipe_flush_ack = 1'b1;
        chk_acks("busy_n3", 1'b0, 1'b1);
        tick();
        fif.excp_flush_req = 1'b0;
        fif.pipe_flush_ack = 1'b0;
        chk_out("busy_n4", 1'b1, 32'h0000_3000);
`ifdef E203_FLUSH_STAT_EN
        chk("cnt_brch", brch_flush_cnt, 32'd4);
        chk("cnt_excp", excp_flush_cnt, 32'd2);
`else
        chk("cnt_brch_off", brch_flush_cnt, 32'd0);
        chk("cnt_excp_off", excp_flush_cnt, 32'd0);
`endif

        // Asynchronous reset while PEND.
        #2 rst_n = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 32'd0);
        chk("rst_mid_bcnt", brch_flush_cnt, 32'd0);
        chk("rst_mid_ecnt", excp_flush_cnt, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk_out("rst_after", 1'b0, 32'd0);
        fif.excp_flush_req = 1'b1;
        fif.excp_flush_pc  = 32'h0000_0044;
        chk_acks("rst_idle", 1'b0, 1'b1);
        tick();
        fif.excp_flush_req = 1'b0;
        chk_out("rst_idle_n1", 1'b1, 32'h0000_0044);
        fif.pipe_flush_ack = 1'b1;
        tick();
        fif.pipe_flush_ack = 1'b0;
        chk_out("final_idle", 1'b0, 32'h0000_0044);

`ifdef E203_FLUSH_STAT_EN
        chk("cnt_excp_after_rst", excp_flush_cnt, 32'd1);
        // Clear together with an acceptance.
        stat_clr = 1'b1;
        fif.brchmis_flush_req     = 1'b1;
        fif.brchmis_flush_add_op1 = 32'h0000_0010;
        fif.brchmis_flush_add_op2 = 32'h0000_0000;
        tick();
        stat_clr = 1'b0;
        fif.brchmis_flush_req = 1'b0;
        chk("clr_bcnt", brch_flush_cnt, 32'd0);
        chk("clr_ecnt", excp_flush_cnt, 32'd0);
        fif.pipe_flush_ack = 1'b1;
        tick();
        fif.pipe_flush_ack = 1'b0;
        // Saturation from a preloaded maximum.
        force dut.brch_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.brch_cnt_q;
        fif.brchmis_flush_req = 1'b1;
        tick();
        fif.brchmis_flush_req = 1'b0;
        chk("sat_bcnt", brch_flush_cnt, 32'hFFFF_FFFF);
`else
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("off_bcnt", brch_flush_cnt, 32'd0);
        chk("off_ecnt", excp_flush_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
